// File: rtl/full_adder.sv
// Parameterised ripple-carry adder built from full-adder cells.
// Sum/Cout are purely combinational so instances can be chained Cout->Ci
// within one cycle; Sum_r/Cout_r/Ovf_r are registered copies with a
// synchronous active-high reset.
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             Cout,
    output logic [WIDTH-1:0] Sum,
    output logic [WIDTH-1:0] Sum_r,
    output logic             Cout_r,
    output logic             Ovf_r
);

    // c[i] is the carry into cell i; c[0] is the external carry-in.
    logic [WIDTH:0] c;
    logic           ovf;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;

    assign c[0] = Ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign Sum[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1]   = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end

    assign Cout = c[WIDTH];
    // For WIDTH=1, c[WIDTH-1] is c[0], i.e. the carry-in itself.
    assign ovf  = c[WIDTH] ^ c[WIDTH-1];

    // Next-state values for the output registers: the current result.
    always_comb begin
        sum_d  = Sum;
        cout_d = Cout;
        ovf_d  = ovf;
    end

    // Output registers; reset wins over loading a new result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Sum_r  = sum_q;
    assign Cout_r = cout_q;
    assign Ovf_r  = ovf_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: a 1-bit instance, a 4-bit instance and
// a chain of four 1-bit instances linked Cout->Ci.
module tb_full_adder;

    typedef enum int {K_C1, K_R1, K_C4, K_R4, K_CC, K_RC} kind_t;

    typedef struct {
        kind_t       kind;
        logic [15:0] exp;
        int          tag;
    } item_t;

    // 4-bit directed vector: inputs, reset, comb {Cout,Sum}, reg {Ovf,Cout,Sum}
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic       rst;
        logic [4:0] c;
        logic [5:0] r;
    } vec4_t;

    // 1-bit directed vector: inputs, comb {Cout,Sum}, reg {Ovf,Cout,Sum}
    typedef struct packed {
        logic       a;
        logic       b;
        logic       ci;
        logic [1:0] c;
        logic [2:0] r;
    } vec1_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    logic clk = 1'b0;
    logic reset;

    logic a1, b1, ci1, cout1, sum1, sumr1, coutr1, ovfr1;
    logic [3:0] a4, b4, sum4, sumr4;
    logic       ci4, cout4, coutr4, ovfr4;

    logic [3:0] ca, cb, cs, csr, ccr, cov;
    logic       cci;
    logic [4:1] cc;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .A(a1), .B(b1), .Ci(ci1),
        .Cout(cout1), .Sum(sum1), .Sum_r(sumr1), .Cout_r(coutr1), .Ovf_r(ovfr1)
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .A(a4), .B(b4), .Ci(ci4),
        .Cout(cout4), .Sum(sum4), .Sum_r(sumr4), .Cout_r(coutr4), .Ovf_r(ovfr4)
    );

    full_adder #(.WIDTH(1)) u_c0 (
        .clk(clk), .reset(reset), .A(ca[0]), .B(cb[0]), .Ci(cci),
        .Cout(cc[1]), .Sum(cs[0]), .Sum_r(csr[0]), .Cout_r(ccr[0]), .Ovf_r(cov[0])
    );
    full_adder #(.WIDTH(1)) u_c1 (
        .clk(clk), .reset(reset), .A(ca[1]), .B(cb[1]), .Ci(cc[1]),
        .Cout(cc[2]), .Sum(cs[1]), .Sum_r(csr[1]), .Cout_r(ccr[1]), .Ovf_r(cov[1])
    );
    full_adder #(.WIDTH(1)) u_c2 (
        .clk(clk), .reset(reset), .A(ca[2]), .B(cb[2]), .Ci(cc[2]),
        .Cout(cc[3]), .Sum(cs[2]), .Sum_r(csr[2]), .Cout_r(ccr[2]), .Ovf_r(cov[2])
    );
    full_adder #(.WIDTH(1)) u_c3 (
        .clk(clk), .reset(reset), .A(ca[3]), .B(cb[3]), .Ci(cc[3]),
        .Cout(cc[4]), .Sum(cs[3]), .Sum_r(csr[3]), .Cout_r(ccr[3]), .Ovf_r(cov[3])
    );

    task automatic push(input kind_t k, input logic [15:0] e, input int tag);
        item_t it;
        it.kind = k;
        it.exp  = e;
        it.tag  = tag;
        sb.push_back(it);
    endtask

    // Signed 4-bit overflow from the arithmetic range, not from carries.
    function automatic logic ovf4(input int a, input int b, input int ci);
        int sa;
        int sb_;
        int s;
        sa = (a >= 8) ? a - 16 : a;
        sb_ = (b >= 8) ? b - 16 : b;
        s  = sa + sb_ + ci;
        return (s > 7) || (s < -8);
    endfunction

    // Expected {Sum_r[3:0], Cout_r[3:0], Ovf_r[3:0]} of the 1-bit chain.
    function automatic logic [11:0] chain_reg(input int a, input int b, input int ci);
        logic [3:0] co;
        logic [3:0] ov;
        int full;
        int cin;
        int m;
        int cy;
        full = a + b + ci;
        cin  = ci;
        for (int i = 0; i < 4; i++) begin
            m     = (1 << (i + 1)) - 1;
            cy    = (((a & m) + (b & m) + ci) >> (i + 1)) & 1;
            co[i] = cy[0];
            ov[i] = cy[0] ^ cin[0];
            cin   = cy;
        end
        return {full[3:0], co, ov};
    endfunction

    // Monitor: outputs are settled at the falling edge; drain every pending item.
    logic [15:0] act;
    string       kname;
    always @(negedge clk) begin
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            act = '0;
            case (it.kind)
                K_C1: begin act = {14'd0, cout1, sum1};          kname = "comb_w1"; end
                K_R1: begin act = {13'd0, ovfr1, coutr1, sumr1}; kname = "reg_w1";  end
                K_C4: begin act = {11'd0, cout4, sum4};          kname = "comb_w4"; end
                K_R4: begin act = {10'd0, ovfr4, coutr4, sumr4}; kname = "reg_w4";  end
                K_CC: begin act = {11'd0, cc[4], cs};            kname = "comb_chain"; end
                default: begin act = {4'd0, csr, ccr, cov};      kname = "reg_chain"; end
            endcase
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s tag=%0d actual=%h required=%h", kname, it.tag, act, it.exp);
            end
        end
    end

    vec4_t t4[9];
    vec1_t t1[8];

    initial begin
        t4[0] = {4'b0111, 4'b0001, 1'b0, 1'b0, 5'b01000, 6'b101000};
        t4[1] = {4'b1111, 4'b1111, 1'b1, 1'b0, 5'b11111, 6'b011111};
        t4[2] = {4'b1010, 4'b0101, 1'b1, 1'b1, 5'b10000, 6'b000000};
        t4[3] = {4'b1010, 4'b0101, 1'b1, 1'b0, 5'b10000, 6'b010000};
        t4[4] = {4'b0011, 4'b0100, 1'b0, 1'b0, 5'b00111, 6'b000111};
        t4[5] = {4'b1111, 4'b0000, 1'b1, 1'b0, 5'b10000, 6'b010000};
        t4[6] = {4'b0000, 4'b0000, 1'b0, 1'b0, 5'b00000, 6'b000000};
        t4[7] = {4'b0100, 4'b0100, 1'b0, 1'b0, 5'b01000, 6'b101000};
        t4[8] = {4'b1000, 4'b1000, 1'b0, 1'b0, 5'b10000, 6'b110000};

        t1[0] = {1'b0, 1'b0, 1'b0, 2'b00, 3'b000};
        t1[1] = {1'b0, 1'b0, 1'b1, 2'b01, 3'b101};
        t1[2] = {1'b0, 1'b1, 1'b0, 2'b01, 3'b001};
        t1[3] = {1'b0, 1'b1, 1'b1, 2'b10, 3'b010};
        t1[4] = {1'b1, 1'b0, 1'b0, 2'b01, 3'b001};
        t1[5] = {1'b1, 1'b0, 1'b1, 2'b10, 3'b010};
        t1[6] = {1'b1, 1'b1, 1'b0, 2'b10, 3'b110};
        t1[7] = {1'b1, 1'b1, 1'b1, 2'b11, 3'b011};

        reset = 1'b1;
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
        ca = 4'hF; cb = 4'hF; cci = 1'b1;

        // Reset state of every registered output.
        @(posedge clk); #1;
        push(K_R1, 16'd0, 0);
        push(K_R4, 16'd0, 0);
        push(K_RC, 16'd0, 0);
        reset = 1'b0;

        // 4-bit directed vectors, including reset mid-run and boundaries.
        // Each registered check is pushed right before the next input change,
        // so it also confirms the registers ignore that change until the edge.
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                push(K_R4, {10'd0, t4[i-1].r}, 100 + i - 1);
            end
            reset = t4[i].rst;
            a4 = t4[i].a; b4 = t4[i].b; ci4 = t4[i].ci;
            push(K_C4, {11'd0, t4[i].c}, 100 + i);
        end
        @(posedge clk); #1;
        push(K_R4, {10'd0, t4[8].r}, 108);
        reset = 1'b0;

        // All eight 1-bit combinations.
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                push(K_R1, {13'd0, t1[i-1].r}, 200 + i - 1);
            end
            a1 = t1[i].a; b1 = t1[i].b; ci1 = t1[i].ci;
            push(K_C1, {14'd0, t1[i].c}, 200 + i);
        end
        @(posedge clk); #1;
        push(K_R1, {13'd0, t1[7].r}, 207);

        // Exhaustive 4-bit sweep on the chain and the 4-bit instance.
        for (int v = 0; v < 512; v++) begin
            int a;
            int b;
            int ci;
            int full;
            if (v > 0) begin
                int pa;
                int pb;
                int pc;
                int pf;
                pa = ((v - 1) >> 5) & 15;
                pb = ((v - 1) >> 1) & 15;
                pc = (v - 1) & 1;
                pf = pa + pb + pc;
                @(posedge clk); #1;
                push(K_R4, {10'd0, ovf4(pa, pb, pc), pf[4:0]}, 1000 + v - 1);
                push(K_RC, {4'd0, chain_reg(pa, pb, pc)}, 1000 + v - 1);
            end
            a  = (v >> 5) & 15;
            b  = (v >> 1) & 15;
            ci = v & 1;
            full = a + b + ci;
            a4 = a[3:0]; b4 = b[3:0]; ci4 = ci[0];
            ca = a[3:0]; cb = b[3:0]; cci = ci[0];
            push(K_C4, {11'd0, full[4:0]}, 1000 + v);
            push(K_CC, {11'd0, full[4:0]}, 1000 + v);
        end
        @(posedge clk); #1;
        // Last vector: 15 + 15 + 1 = 31, signed -1 + -1 + 1 = -1.
        push(K_R4, 16'b0000_0000_0001_1111, 1511);
        push(K_RC, {4'd0, chain_reg(15, 15, 1)}, 1511);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 4 && sb.size() != 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all registered outputs update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled only on the rising edge of clk.
REQ-004 A  input  WIDTH  addend A, unsigned (two's complement for the overflow flag).
REQ-005 B  input  WIDTH  addend B, same encoding as A.
REQ-006 Ci  input  1  carry-in into bit 0.
REQ-007 Cout  output  1  combinational carry-out of the MSB.
REQ-008 Sum  output  WIDTH  combinational sum bits.
REQ-009 Sum_r  output  WIDTH  registered copy of Sum.
REQ-010 Cout_r  output  1  registered copy of Cout.
REQ-011 Ovf_r  output  1  registered signed-overflow flag.

Function
REQ-012 Bit i of the design SHALL be a full-adder cell: Sum[i] = A[i] xor B[i] xor c[i]; c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]); c[0] = Ci; Cout = c[WIDTH].
REQ-013 The carry SHALL propagate bit by bit (ripple) across all WIDTH cells.
REQ-014 {Cout, Sum} SHALL equal A + B + Ci exactly, computed in WIDTH+1 bits with no truncation.
REQ-015 Sum and Cout SHALL be purely combinational, with zero clock latency.
REQ-016 Sum and Cout SHALL be independent of clk and reset, so that cells can be chained Cout to Ci within one cycle.
REQ-017 Overflow SHALL be defined as c[WIDTH] xor c[WIDTH-1].
REQ-018 When WIDTH=1, the overflow term c[WIDTH-1] SHALL be Ci.
REQ-019 On each rising clk edge with reset low, Sum_r, Cout_r and Ovf_r SHALL load the current Sum, Cout and overflow, giving exactly 1 cycle of latency.
REQ-020 Registered outputs SHALL hold their value between clock edges.
REQ-021 Changes on the inputs between edges SHALL affect only the combinational outputs.
REQ-022 Boundary: all-ones operands with Ci=1 SHALL give Sum all ones and Cout=1 (for WIDTH=4: 1111+1111+1 = 1_1111).
REQ-023 Boundary: all-zero operands with Ci=0 SHALL give Sum=0 and Cout=0.
REQ-024 Wrap-around: A all ones, B=0, Ci=1 SHALL give Sum=0 and Cout=1.
REQ-025 The design SHALL contain no latches.
REQ-026 No output SHALL be X or Z when all inputs are known.

Reset
REQ-027 When reset is high at a rising clk edge, Sum_r SHALL be 0, Cout_r SHALL be 0 and Ovf_r SHALL be 0 after that edge.
REQ-028 Reset SHALL take priority over loading new results.
REQ-029 Reset asserted mid-operation SHALL clear the registered outputs on the next edge without altering the combinational Sum or Cout.
REQ-030 After reset is deasserted, the first rising edge SHALL load the current result.

Verification
REQ-031 WIDTH=1, all 8 combinations of A, B, Ci -> {Cout, Sum} = A+B+Ci; e.g. 1,1,1 -> Cout=1, Sum=1 and 1,0,0 -> Cout=0, Sum=1.
REQ-032 Four WIDTH=1 instances chained Cout to Ci, with A=0..15, B=0..15 and Ci in {0,1} (512 vectors) -> each 5-bit result equals A+B+Ci; e.g. 0111+0001+0 -> Cout=0, Sum=1000.
REQ-033 WIDTH=4, A=0111, B=0001, Ci=0, one clock edge -> Sum_r=1000, Cout_r=0, Ovf_r=1.
REQ-034 WIDTH=4, A=1111, B=1111, Ci=1 -> combinational Sum=1111, Cout=1 immediately; after one edge Sum_r=1111, Cout_r=1, Ovf_r=0.
REQ-035 Reset high for one edge while A=1010, B=0101, Ci=1 -> Sum_r=0000, Cout_r=0, Ovf_r=0, while combinational Sum=0000, Cout=1.
REQ-036 Inputs toggled between edges with reset low -> registered outputs unchanged until the next rising edge.
